qpp_interleaver: RTL and testbench
==================================

# qpp_interleaver

- Parametrised, double-buffered block interleaver/deinterleaver for the turbo encoder and max-product decoder datapath.
- Permutation is the quadratic permutation polynomial pi(i) = (F1·i + F2·i²) mod K.
- One bank is written while the other is read, giving sustained one-sample-per-cycle throughput.
- Direction is selectable per frame, so the same block serves both the interleaver and the deinterleaver positions between constituent decoders.

## Interface

Parameters:
- K, 40, frame length in samples (≥2)
- W, 8, sample width in bits
- F1, 3, QPP linear coefficient (< K)
- F2, 10, QPP quadratic coefficient (< K)
- AW, $clog2(K), derived address width, not overridden

Ports:
- clk  in  1  single clock, all logic rising-edge
- rst_n  in  1  asynchronous active-low reset
- mode  in  1  0 = interleave, 1 = deinterleave; sampled with the first accepted sample of each frame
- in_valid  in  1  input sample valid
- in_ready  out  1  write bank available
- in_data  in  W  input sample
- out_valid  out  1  output sample valid
- out_ready  in  1  downstream accepts
- out_data  out  W  output sample
- out_last  out  1  high with the K-th sample of a frame

## Operation

- Storage:
  - Two banks, each K×W register array with asynchronous read.
  - Per bank: full flag and captured mode bit.
- Write side:
  - wr_bank pointer and index i counting 0..K-1.
  - Transfer when in_valid && in_ready.
  - in_ready = !full[wr_bank].
  - Write address is i (interleave) or pi(i) (deinterleave).
  - At i = K-1 the transfer sets full[wr_bank], toggles wr_bank and clears i.
- Read side:
  - rd_bank pointer and index j.
  - out_valid = full[rd_bank].
  - Read address is pi(j) (interleave) or j (deinterleave), using that bank's captured mode.
  - out_last = out_valid && j == K-1.
  - Transfer at K-1 clears full[rd_bank], toggles rd_bank and clears j.
- Result:
  - Interleave: out[j] = in[pi(j)].
  - Deinterleave: out[pi(i)] = in[i].
- QPP generator (one per side), incremental, no multipliers:
  - pi(0) = 0
  - g(0) = (F1+F2) mod K
  - pi(n+1) = (pi(n) + g(n)) mod K
  - g(n+1) = (g(n) + S) mod K, with S = (2·F2) mod K fixed at elaboration
  - All operands < K, so each mod is a single conditional subtract of K on an AW+1-bit sum.
  - Generator advances on each transfer of its side and reloads pi=0, g=g(0) at frame end.
- Simultaneous events: a same-cycle set and clear of full flags always target different banks (writer never writes a full bank; reader reads only full banks). Both take effect.
- Both full: in_ready low until the reader finishes a frame.
- Legality of the F1/F2 pair (bijective permutation) is the integrator's responsibility; the block does not check it.

## Timing

- Reset values (asynchronous, immediate on rst_n low):
  - in_ready = 1
  - out_valid = 0, out_last = 0
  - out_data = mem[0][0] content (don't-care while out_valid = 0)
  - Both full flags = 0, wr_bank = rd_bank = 0, i = j = 0, generators at initial state
- Reset mid-frame discards partial and buffered frames; bank contents are not cleared.
- Latency: last sample of a frame accepted at edge t gives out_valid = 1 after edge t (next cycle). First out_data is combinationally valid in that cycle.
- Throughput: 1 sample/cycle in and out sustained once the pipeline holds one frame.
- out_data/out_last are held stable while out_valid && !out_ready.
- mode changes mid-frame are ignored until the next frame's first sample.

## Configuration

- QPP_INTERLEAVER_DEINT_EN defined:
  - Full behaviour as above.
  - Two QPP generators; per-bank mode bit stored.
- Not defined:
  - mode port present but ignored; block is interleave-only.
  - Write address always i; one QPP generator on the read side.
  - No per-bank mode storage.

## Test plan

- K=40, F1=3, F2=10, mode=0, in_data=i for i=0..39, out_ready=1 → out_data sequence 0,13,6,19,… matching pi(j); out_last only on 40th output; out_valid first high the cycle after the 40th input.
- Feed the interleaved output from the previous case back in with mode=1 → output 0,1,2,…,39.
- Three back-to-back frames with in_valid held high and out_ready=1 → in_ready never drops after the first frame; all 120 outputs correct; no bubbles.
- out_ready=0 with continuous input → in_ready falls after exactly 80 accepted samples; out_data/out_last stable; releasing out_ready drains both frames in order.
- rst_n pulsed low after 25 samples of frame 2 while frame 1 is mid-read → out_valid=0, in_ready=1 immediately; the next full frame is output correctly from bank 0.
- Random in_valid/out_ready throttling, alternating mode per frame, over 50 frames → outputs match the reference-model permutation per frame's captured mode.

Source files
------------

// File: rtl/qpp_interleaver.sv
// qpp_interleaver
// ---------------
// Double-buffered QPP block interleaver / deinterleaver. One bank is written
// while the other is read, so a steady stream moves one sample per cycle in
// and out once a frame is buffered.
//
//   pi(i) = (F1*i + F2*i^2) mod K
//
// The permutation is produced incrementally (pi += g, g += 2*F2, both mod K)
// so no multipliers are needed; every mod is a single conditional subtract.
//
// Optional feature macro: QPP_INTERLEAVER_DEINT_EN
//   defined   : per-frame direction select through 'mode' (captured with the
//               first accepted sample of a frame and stored per bank).
//   undefined : interleave only; 'mode' is ignored.
//
// Ports
//   clk        in   1  clock, rising edge
//   rst_n      in   1  asynchronous active-low reset
//   mode       in   1  0 = interleave, 1 = deinterleave
//   in_valid   in   1  input sample valid
//   in_ready   out  1  a write bank is free
//   in_data    in   W  input sample
//   out_valid  out  1  output sample valid (read bank full)
//   out_ready  in   1  downstream accepts
//   out_data   out  W  output sample (combinational bank read)
//   out_last   out  1  high with the K-th output of a frame

module qpp_interleaver #(
  parameter int K  = 40,
  parameter int W  = 8,
  parameter int F1 = 3,
  parameter int F2 = 10,
  parameter int AW = $clog2(K)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         mode,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last
);

  localparam logic [AW:0]   K_EXT  = (AW+1)'(K);
  localparam logic [AW-1:0] K_LAST = AW'(K - 1);
  localparam logic [AW-1:0] G0     = AW'((F1 + F2) % K);
  localparam logic [AW-1:0] S_STEP = AW'((2 * F2) % K);

  // (a + b) mod K for operands already below K
  function automatic logic [AW-1:0] mod_add(input logic [AW-1:0] a,
                                            input logic [AW-1:0] b);
    logic [AW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= K_EXT) s = s - K_EXT;
    return s[AW-1:0];
  endfunction

  // Sample storage: data only, never reset
  logic [W-1:0]  r_mem [2][K];

  // Control state
  logic [1:0]    r_full;
  logic          r_wr_bank;
  logic          r_rd_bank;
  logic [AW-1:0] r_wr_idx;
  logic [AW-1:0] r_rd_idx;
  logic [AW-1:0] r_rd_pi;
  logic [AW-1:0] r_rd_g;

  logic          w_wr_fire;
  logic          w_wr_end;
  logic          w_rd_fire;
  logic          w_rd_end;
  logic [1:0]    w_full_set;
  logic [1:0]    w_full_clr;
  logic [AW-1:0] w_wr_addr;
  logic [AW-1:0] w_rd_addr;

  assign in_ready   = !r_full[r_wr_bank];
  assign out_valid  = r_full[r_rd_bank];
  assign out_last   = out_valid && (r_rd_idx == K_LAST);

  assign w_wr_fire  = in_valid && in_ready;
  assign w_wr_end   = (r_wr_idx == K_LAST);
  assign w_rd_fire  = out_valid && out_ready;
  assign w_rd_end   = (r_rd_idx == K_LAST);

  // Set and clear can coincide but always address different banks
  assign w_full_set = (w_wr_fire && w_wr_end) ? (2'b01 << r_wr_bank) : 2'b00;
  assign w_full_clr = (w_rd_fire && w_rd_end) ? (2'b01 << r_rd_bank) : 2'b00;

`ifdef QPP_INTERLEAVER_DEINT_EN
  logic [1:0]    r_bank_mode;
  logic [AW-1:0] r_wr_pi;
  logic [AW-1:0] r_wr_g;

  // At i = 0 both address choices are 0, so a stale mode bit for the
  // bank being opened cannot misplace the first sample.
  assign w_wr_addr = r_bank_mode[r_wr_bank] ? r_wr_pi : r_wr_idx;
  assign w_rd_addr = r_bank_mode[r_rd_bank] ? r_rd_idx : r_rd_pi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bank_mode <= 2'b00;
      r_wr_pi     <= '0;
      r_wr_g      <= G0;
    end else if (w_wr_fire) begin
      if (r_wr_idx == '0) r_bank_mode[r_wr_bank] <= mode;
      if (w_wr_end) begin
        r_wr_pi <= '0;
        r_wr_g  <= G0;
      end else begin
        r_wr_pi <= mod_add(r_wr_pi, r_wr_g);
        r_wr_g  <= mod_add(r_wr_g, S_STEP);
      end
    end
  end
`else
  logic w_unused_mode;
  assign w_unused_mode = mode;
  assign w_wr_addr     = r_wr_idx;
  assign w_rd_addr     = r_rd_pi;
`endif

  assign out_data = r_mem[r_rd_bank][w_rd_addr];

  always_ff @(posedge clk) begin
    if (w_wr_fire) r_mem[r_wr_bank][w_wr_addr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full    <= 2'b00;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_wr_idx  <= '0;
      r_rd_idx  <= '0;
      r_rd_pi   <= '0;
      r_rd_g    <= G0;
    end else begin
      r_full <= (r_full | w_full_set) & ~w_full_clr;

      if (w_wr_fire) begin
        if (w_wr_end) begin
          r_wr_idx  <= '0;
          r_wr_bank <= ~r_wr_bank;
        end else begin
          r_wr_idx  <= r_wr_idx + AW'(1);
        end
      end

      if (w_rd_fire) begin
        if (w_rd_end) begin
          r_rd_idx  <= '0;
          r_rd_bank <= ~r_rd_bank;
          r_rd_pi   <= '0;
          r_rd_g    <= G0;
        end else begin
          r_rd_idx  <= r_rd_idx + AW'(1);
          r_rd_pi   <= mod_add(r_rd_pi, r_rd_g);
          r_rd_g    <= mod_add(r_rd_g, S_STEP);
        end
      end
    end
  end

endmodule

// File: tb/tb_qpp_interleaver.sv
module tb_qpp_interleaver;

  localparam int K  = 40;
  localparam int W  = 8;
  localparam int F1 = 3;
  localparam int F2 = 10;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         mode;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_last;

  qpp_interleaver #(.K(K), .W(W), .F1(F1), .F2(F2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Hand-computed pi(j) = (3j + 10j^2) mod 40
  int pi_hand [K] = '{0,13,6,19,12,25,18,31,24,37,30,3,36,9,2,15,8,21,14,27,
                      20,33,26,39,32,5,38,11,4,17,10,23,16,29,22,35,28,1,34,7};

  typedef struct {
    logic [W-1:0] din;
    logic         m;
    logic [W-1:0] dexp;
    logic         lexp;
  } vec_t;
  vec_t tbl [2*K];

  // Reference model / scoreboard
  typedef struct {
    logic [W-1:0] d;
    logic         l;
  } exp_t;
  exp_t         exp_q [$];
  logic [W-1:0] part [K];
  logic [W-1:0] obuf [K];
  int           part_cnt  = 0;
  logic         part_mode = 1'b0;
  bit           mon_en    = 1'b0;

  function automatic int pi_f(input int n);
    return (F1 * n + F2 * n * n) % K;
  endfunction

  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL out_unexpected: got data %0d, expected no output", out_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_data", 32'(out_data), 32'(e.d));
          check("out_last", 32'(out_last), 32'(e.l));
        end
      end
      if (in_valid && in_ready) begin
        if (part_cnt == 0) begin
`ifdef QPP_INTERLEAVER_DEINT_EN
          part_mode = mode;
`else
          part_mode = 1'b0;
`endif
        end
        part[part_cnt] = in_data;
        part_cnt++;
        if (part_cnt == K) begin
          for (int i = 0; i < K; i++) begin
            if (part_mode) obuf[pi_f(i)] = part[i];
            else           obuf[i]       = part[pi_f(i)];
          end
          for (int j = 0; j < K; j++) exp_q.push_back('{obuf[j], (j == K-1)});
          part_cnt = 0;
        end
      end
    end
  end

  task automatic flush_model();
    exp_q.delete();
    part_cnt = 0;
  endtask

  // Directed frame from the table: write K samples, then read K samples
  task automatic apply_frame(input int base);
    for (int j = 0; j < K; j++) begin
      @(posedge clk); #1;
      in_valid  = 1'b1;
      in_data   = tbl[base+j].din;
      mode      = tbl[base+j].m;
      out_ready = 1'b1;
      @(negedge clk);
      check("wr_in_ready", 32'(in_ready), 32'd1);
      check("wr_out_valid", 32'(out_valid), 32'd0);
    end
    for (int j = 0; j < K; j++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      mode     = ~mode;
      @(negedge clk);
      check("rd_out_valid", 32'(out_valid), 32'd1);
      check("rd_out_data", 32'(out_data), 32'(tbl[base+j].dexp));
      check("rd_out_last", 32'(out_last), 32'(tbl[base+j].lexp));
    end
    @(posedge clk); #1;
    @(negedge clk);
    check("post_out_valid", 32'(out_valid), 32'd0);
    check("post_in_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic run_stream(input int n_acc, input int pv, input int pr,
                            input bit mrand, input bit mfix, input int limit);
    int acc;
    acc = 0;
    for (int c = 0; c < limit && acc < n_acc; c++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(99) < pv);
      in_data   = W'($urandom);
      mode      = mrand ? 1'($urandom_range(1)) : mfix;
      out_ready = ($urandom_range(99) < pr);
      @(negedge clk);
      if (in_valid && in_ready) acc++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("stream_accepted", 32'(acc), 32'(n_acc));
  endtask

  task automatic drain(input int limit);
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int c = 0; c < limit; c++) begin
      @(posedge clk); #2;
      if (exp_q.size() == 0 && !out_valid) break;
    end
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    check("drain_out_valid", 32'(out_valid), 32'd0);
    check("drain_partial", 32'(part_cnt), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
    $fatal(1);
  end

  initial begin
    int acc;

    for (int j = 0; j < K; j++) begin
      tbl[j] = '{W'(j), 1'b0, W'(pi_hand[j]), (j == K-1)};
`ifdef QPP_INTERLEAVER_DEINT_EN
      tbl[K+j] = '{W'(pi_hand[j]), 1'b1, W'(j), (j == K-1)};
`else
      tbl[K+j] = '{W'(pi_hand[j]), 1'b1, W'(pi_hand[pi_hand[j]]), (j == K-1)};
`endif
    end

    rst_n = 1'b0; mode = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #3;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    #9 rst_n = 1'b1;

    // Interleave 0..39, then feed the result back as a deinterleave frame
    apply_frame(0);
    apply_frame(K);

    // Three back-to-back frames, no bubbles on either side
    mon_en = 1'b1;
    for (int c = 0; c < 4*K; c++) begin
      @(posedge clk); #1;
      in_valid  = (c < 3*K);
      in_data   = W'(c);
      mode      = 1'((c / K) % 2);
      out_ready = 1'b1;
      @(negedge clk);
      if (c < 3*K) check("b2b_in_ready", 32'(in_ready), 32'd1);
      if (c >= K)  check("b2b_out_valid", 32'(out_valid), 32'd1);
    end
    drain(200);

    // Back-pressure: both banks fill, output held stable
    out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = W'($urandom);
      mode     = 1'($urandom_range(1));
      @(negedge clk);
      if (!in_ready) break;
      acc++;
      if (out_valid) begin
        check("stall_out_data", 32'(out_data), 32'(exp_q[0].d));
        check("stall_out_last", 32'(out_last), 32'd0);
      end
    end
    check("stall_accept_count", 32'(acc), 32'(2*K));
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_out_data", 32'(out_data), 32'(exp_q[0].d));
      @(posedge clk); #1;
    end
    drain(300);

    // Reset while frame 1 is mid-read and frame 2 is partly written
    run_stream(K + 25, 100, 100, 1'b1, 1'b0, 500);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_last", 32'(out_last), 32'd0);
    flush_model();
    @(posedge clk); @(posedge clk); #2 rst_n = 1'b1;
    run_stream(K, 100, 100, 1'b0, 1'b0, 500);
    drain(200);

    // Random throttling, mode toggling freely (captured per frame)
    run_stream(50*K, 70, 70, 1'b1, 1'b0, 20000);
    drain(2000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
